// File: rtl/ias_pkg.sv
// Mode encodings and sizing helper shared by the instruction address unit and its return-address stack.
package ias_pkg;

    localparam logic [1:0] MODE_INC      = 2'b00;
    localparam logic [1:0] MODE_BRANCH   = 2'b01;
    localparam logic [1:0] MODE_JUMP_REG = 2'b10;
    localparam logic [1:0] MODE_RETURN   = 2'b11;

    function automatic int ras_ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address stack: top is combinational from storage, updates land on the next edge.
// No backpressure; a push while full silently overwrites the oldest entry and pulses overflow.
module return_addr_stack
    import ias_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned RAS_DEPTH  = 8
) (
    input  logic                                Clock,
    input  logic                                Reset_n,
    input  logic                                push,
    input  logic                                pop,
    input  logic [ADDR_WIDTH-1:0]               push_data,
    output logic [ADDR_WIDTH-1:0]               top,
    output logic [ras_ptr_width(RAS_DEPTH):0]   count,
    output logic                                overflow,
    output logic                                underflow
);

    localparam int PTR_W = ras_ptr_width(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]      topPtr;
    logic                  empty;
    logic                  full;
    logic [PTR_W-1:0]      writePtr;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(RAS_DEPTH));
    assign top       = mem[topPtr];
    assign overflow  = push && !pop && full;
    assign underflow = pop && empty;

    // Pop+push rewrites the current top in place; a plain push advances onto the next slot,
    // which when full is exactly the oldest entry.
    assign writePtr  = pop ? topPtr : topPtr + PTR_W'(1);

    always_ff @(posedge Clock) begin
        if (push) begin
            mem[writePtr] <= push_data;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            topPtr <= '0;
            count  <= '0;
        end else if (push && pop) begin
            if (empty) begin
                count <= CNT_W'(1);
            end
        end else if (push) begin
            topPtr <= topPtr + PTR_W'(1);
            if (!full) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            topPtr <= topPtr - PTR_W'(1);
            count  <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/instruction_address_unit.sv
// Fetch PC generator with branch/jump/return modes, call/return stack and priority redirect.
// One-cycle latency; PC_enable=0 stalls all state, Redirect overrides the stall.
module instruction_address_unit
    import ias_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter int unsigned            RAS_DEPTH  = 8,
    parameter logic [ADDR_WIDTH-1:0]  RESET_ADDR = '0,
    parameter int unsigned            PC_STEP    = 1
) (
    input  logic                                Clock,
    input  logic                                Reset_n,
    input  logic                                PC_enable,
    input  logic [1:0]                          Mode,
    input  logic [ADDR_WIDTH-1:0]               BranchOff,
    input  logic [ADDR_WIDTH-1:0]               RA,
    input  logic                                Call,
    input  logic                                Redirect,
    input  logic [ADDR_WIDTH-1:0]               Redirect_addr,
    input  logic                                Clear_flags,
    output logic [ADDR_WIDTH-1:0]               PC,
    output logic [ADDR_WIDTH-1:0]               PC_temp,
    output logic [ras_ptr_width(RAS_DEPTH):0]   RAS_count,
    output logic                                RAS_overflow,
    output logic                                RAS_underflow
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

    logic                  advance;
    logic                  rasPush;
    logic                  rasPop;
    logic [ADDR_WIDTH-1:0] rasTop;
    logic                  rasOverflowEvt;
    logic                  rasUnderflowEvt;
    logic [ADDR_WIDTH-1:0] seqPC;
    logic [ADDR_WIDTH-1:0] nextPC;

    assign advance = PC_enable && !Redirect;
    assign rasPush = advance && Call;
    assign rasPop  = advance && (Mode == MODE_RETURN);
    assign seqPC   = PC + STEP;

    return_addr_stack #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAS_DEPTH  (RAS_DEPTH)
    ) u_ras (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .push       (rasPush),
        .pop        (rasPop),
        .push_data  (seqPC),
        .top        (rasTop),
        .count      (RAS_count),
        .overflow   (rasOverflowEvt),
        .underflow  (rasUnderflowEvt)
    );

    always_comb begin
        nextPC = seqPC;
        case (Mode)
            MODE_INC:      nextPC = seqPC;
            MODE_BRANCH:   nextPC = PC + BranchOff;
            MODE_JUMP_REG: nextPC = RA;
            MODE_RETURN:   nextPC = (RAS_count != '0) ? rasTop : RA;
            default:       nextPC = seqPC;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            PC      <= RESET_ADDR;
            PC_temp <= RESET_ADDR;
        end else if (Redirect) begin
            PC      <= Redirect_addr;
            PC_temp <= PC;
        end else if (PC_enable) begin
            PC      <= nextPC;
            PC_temp <= PC;
        end
    end

    // Set events outrank a same-cycle clear so no overflow/underflow is ever lost.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            RAS_overflow  <= 1'b0;
            RAS_underflow <= 1'b0;
        end else begin
            if (rasOverflowEvt) begin
                RAS_overflow <= 1'b1;
            end else if (Clear_flags) begin
                RAS_overflow <= 1'b0;
            end
            if (rasUnderflowEvt) begin
                RAS_underflow <= 1'b1;
            end else if (Clear_flags) begin
                RAS_underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_address_unit.sv
// Directed table-driven bench for instruction_address_unit plus a hand sequence for asynchronous reset.
module tb_instruction_address_unit;

    localparam logic [1:0] INC = 2'b00;
    localparam logic [1:0] BR  = 2'b01;
    localparam logic [1:0] JR  = 2'b10;
    localparam logic [1:0] RET = 2'b11;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        PC_enable = 1'b0;
    logic [1:0]  Mode = INC;
    logic [31:0] BranchOff = '0;
    logic [31:0] RA = '0;
    logic        Call = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] Redirect_addr = '0;
    logic        Clear_flags = 1'b0;
    logic [31:0] PC;
    logic [31:0] PC_temp;
    logic [3:0]  RAS_count;
    logic        RAS_overflow;
    logic        RAS_underflow;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        logic        en;
        logic [1:0]  mode;
        logic [31:0] off;
        logic [31:0] ra;
        logic        call;
        logic        redir;
        logic [31:0] raddr;
        logic        clr;
        logic [31:0] ePC;
        logic [31:0] eTmp;
        logic [3:0]  eCnt;
        logic        eOvf;
        logic        eUnf;
    } vec_t;

    vec_t vecs[$];

    instruction_address_unit #(
        .ADDR_WIDTH (32),
        .RAS_DEPTH  (8),
        .RESET_ADDR (32'h0),
        .PC_STEP    (1)
    ) dut (
        .Clock         (Clock),
        .Reset_n       (Reset_n),
        .PC_enable     (PC_enable),
        .Mode          (Mode),
        .BranchOff     (BranchOff),
        .RA            (RA),
        .Call          (Call),
        .Redirect      (Redirect),
        .Redirect_addr (Redirect_addr),
        .Clear_flags   (Clear_flags),
        .PC            (PC),
        .PC_temp       (PC_temp),
        .RAS_count     (RAS_count),
        .RAS_overflow  (RAS_overflow),
        .RAS_underflow (RAS_underflow)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] ePC, input logic [31:0] eTmp,
                             input logic [3:0] eCnt, input logic eOvf, input logic eUnf);
        check({tag, ".PC"}, PC, ePC);
        check({tag, ".PC_temp"}, PC_temp, eTmp);
        check({tag, ".RAS_count"}, 32'(RAS_count), 32'(eCnt));
        check({tag, ".RAS_overflow"}, 32'(RAS_overflow), 32'(eOvf));
        check({tag, ".RAS_underflow"}, 32'(RAS_underflow), 32'(eUnf));
    endtask

    task automatic add(input logic en, input logic [1:0] mode, input logic [31:0] off,
                       input logic [31:0] ra, input logic call, input logic redir,
                       input logic [31:0] raddr, input logic clr, input logic [31:0] ePC,
                       input logic [31:0] eTmp, input logic [3:0] eCnt, input logic eOvf,
                       input logic eUnf);
        vec_t v;
        v.en = en; v.mode = mode; v.off = off; v.ra = ra; v.call = call;
        v.redir = redir; v.raddr = raddr; v.clr = clr; v.ePC = ePC; v.eTmp = eTmp;
        v.eCnt = eCnt; v.eOvf = eOvf; v.eUnf = eUnf;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        PC_enable = v.en; Mode = v.mode; BranchOff = v.off; RA = v.ra; Call = v.call;
        Redirect = v.redir; Redirect_addr = v.raddr; Clear_flags = v.clr;
    endtask

    initial begin
        // Sequential from reset, PC_temp lagging by one
        for (int k = 0; k < 4; k++)
            add(1, INC, 0, 0, 0, 0, 0, 0, 32'(k + 1), 32'(k), 0, 0, 0);
        // Negative branch and wrap-around (redirect with PC_enable=0 still applies)
        add(0, INC, 0, 0, 0, 1, 32'd10, 0, 32'd10, 32'd4, 0, 0, 0);
        add(1, BR, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 32'd6, 32'd10, 0, 0, 0);
        add(0, INC, 0, 0, 0, 1, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFF, 32'd6, 0, 0, 0);
        add(1, INC, 0, 0, 0, 0, 0, 0, 32'd0, 32'hFFFF_FFFF, 0, 0, 0);
        add(1, JR, 0, 32'h1234, 0, 0, 0, 0, 32'h1234, 32'd0, 0, 0, 0);
        // Call via branch, then return
        add(0, INC, 0, 0, 0, 1, 32'd20, 0, 32'd20, 32'h1234, 0, 0, 0);
        add(1, BR, 32'd100, 0, 1, 0, 0, 0, 32'd120, 32'd20, 1, 0, 0);
        add(1, RET, 0, 32'hAA, 0, 0, 0, 0, 32'd21, 32'd120, 0, 0, 0);
        // Nine calls into an 8-deep stack
        add(0, INC, 0, 0, 0, 1, 32'd0, 0, 32'd0, 32'd21, 0, 0, 0);
        for (int k = 0; k < 9; k++)
            add(1, INC, 0, 0, 1, 0, 0, 0, 32'(k + 1), 32'(k), (k >= 7) ? 4'd8 : 4'(k + 1), (k == 8), 0);
        // Eight returns unwind 9..2, then one underflowing return
        for (int i = 0; i < 8; i++)
            add(1, RET, 0, 32'h99, 0, 0, 0, 0, 32'(9 - i), (i == 0) ? 32'd9 : 32'(10 - i), 4'(7 - i), 1, 0);
        add(1, RET, 0, 32'h55, 0, 0, 0, 0, 32'h55, 32'd2, 0, 1, 1);
        add(0, INC, 0, 0, 0, 0, 0, 1, 32'h55, 32'd2, 0, 0, 0);
        // Underflow in the same cycle as clear keeps the flag
        add(1, RET, 0, 32'h60, 0, 0, 0, 1, 32'h60, 32'h55, 0, 0, 1);
        add(0, INC, 0, 0, 0, 0, 0, 1, 32'h60, 32'h55, 0, 0, 0);
        // Stall and redirect leave the stack alone
        add(0, INC, 0, 0, 0, 1, 32'h30, 0, 32'h30, 32'h60, 0, 0, 0);
        add(1, INC, 0, 0, 1, 0, 0, 0, 32'h31, 32'h30, 1, 0, 0);
        add(1, INC, 0, 0, 1, 0, 0, 0, 32'h32, 32'h31, 2, 0, 0);
        add(0, RET, 0, 32'h77, 1, 0, 0, 0, 32'h32, 32'h31, 2, 0, 0);
        add(1, RET, 0, 32'h77, 1, 1, 32'h200, 0, 32'h200, 32'h32, 2, 0, 0);
        add(1, RET, 0, 32'h77, 0, 0, 0, 0, 32'h32, 32'h200, 1, 0, 0);
        // Pop+push on non-empty and on empty stack
        add(1, RET, 0, 32'h77, 1, 0, 0, 0, 32'h31, 32'h32, 1, 0, 0);
        add(1, RET, 0, 32'h77, 0, 0, 0, 0, 32'h33, 32'h31, 0, 0, 0);
        add(1, RET, 0, 32'h70, 1, 0, 0, 0, 32'h70, 32'h33, 1, 0, 1);
        add(1, RET, 0, 32'h77, 0, 0, 0, 0, 32'h34, 32'h70, 0, 0, 1);
        // Build up PC=0x40 with three entries for the async reset sequence
        add(0, INC, 0, 0, 0, 1, 32'h3D, 0, 32'h3D, 32'h34, 0, 0, 1);
        add(1, INC, 0, 0, 1, 0, 0, 0, 32'h3E, 32'h3D, 1, 0, 1);
        add(1, INC, 0, 0, 1, 0, 0, 0, 32'h3F, 32'h3E, 2, 0, 1);
        add(1, INC, 0, 0, 1, 0, 0, 0, 32'h40, 32'h3F, 3, 0, 1);

        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check_all("reset", 32'h0, 32'h0, 0, 0, 0);
        Reset_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge Clock);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].ePC, vecs[i].eTmp, vecs[i].eCnt,
                      vecs[i].eOvf, vecs[i].eUnf);
            @(negedge Clock);
        end

        // Asynchronous reset between edges must act without a clock edge
        PC_enable = 1'b0; Call = 1'b0; Redirect = 1'b0; Clear_flags = 1'b0; Mode = INC;
        #2;
        Reset_n = 1'b0;
        #1;
        check_all("async_rst", 32'h0, 32'h0, 0, 0, 0);
        @(negedge Clock);
        Reset_n = 1'b1;
        PC_enable = 1'b1;
        @(posedge Clock);
        #1;
        check_all("post_rst", 32'h1, 32'h0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
